// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue self-test sequencer.
package pq_pkg;

  typedef enum logic [2:0] {
    IDLE, START, ADD, FULL, REMOVE, EMPTY, DISPLAY
  } pq_state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ORDER = 3'd1;
  localparam logic [2:0] ERR_COUNT = 3'd2;
  localparam logic [2:0] ERR_SUM   = 3'd3;
  localparam logic [2:0] ERR_TMO   = 3'd4;

  // Galois right-shift feedback mask (x^16 + x^14 + x^13 + x^11 + 1)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/pq_auto_ctrl_if.sv
// Handshake bundle between the self-test sequencer and the PQ core.
interface pq_auto_ctrl_if #(
  parameter int KW = 16
);
  logic          enq;
  logic          deq;
  logic [KW-1:0] din;
  logic          ready;
  logic          full;
  logic          empty;
  logic [KW-1:0] dout;
  logic          dout_valid;

  modport ctrl (
    output enq, deq, din,
    input  ready, full, empty, dout, dout_valid
  );

  modport core (
    input  enq, deq, din,
    output ready, full, empty, dout, dout_valid
  );
endinterface

// File: rtl/pq_lfsr.sv
// 16-bit Galois LFSR key generator; loads seed on reset or load.
module pq_lfsr
  import pq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  logic [15:0] lfsr_q, lfsr_d;

  // next value: reseed wins over a step
  always_comb begin
    lfsr_d = lfsr_q;
    if (load)
      lfsr_d = seed;
    else if (advance)
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
  end

  // state register, reset reloads the seed
  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= seed;
    else      lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;
endmodule

// File: rtl/pq_auto_ctrl.sv
// Self-test sequencer: fills the PQ with LFSR keys, drains it, and checks
// max-first ordering, element count and checksum.
module pq_auto_ctrl
  import pq_pkg::*;
#(
  parameter int          KW      = 16,
  parameter int          DEPTH   = 16,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  pq_auto_ctrl_if.ctrl                 pq,
  output logic                         sig_idle,
  output logic                         sig_start,
  output logic                         sig_add,
  output logic                         sig_remove,
  output logic                         sig_display,
  output logic                         sig_full,
  output logic                         sig_empty,
  output logic [$clog2(DEPTH+1)-1:0]   n_added,
  output logic [KW-1:0]                last_key,
  output logic                         pass,
  output logic [2:0]                   err_code
);
  localparam int NW = $clog2(DEPTH+1);
  localparam int SW = KW + $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0) ? 16'h1 : SEED;

  pq_state_t       state_q, state_d;
  logic [6:0]      flags_q;
  logic [NW-1:0]   n_add_q, n_add_d, n_rem_q, n_rem_d;
  logic [SW-1:0]   sum_in_q, sum_in_d, sum_out_q, sum_out_d;
  logic [KW-1:0]   prev_q, prev_d, last_q, last_d;
  logic [2:0]      err_q, err_d;
  logic            pass_q, pass_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            out_q, out_d;
  logic            start_q;
  logic            start_rise, enq_c, deq_c, wait_c, lfsr_ld, lfsr_adv;
  logic [15:0]     lfsr_q;
  logic [KW-1:0]   key_c;

  pq_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_ld),
    .advance (lfsr_adv),
    .seed    (SEED_NZ),
    .q       (lfsr_q)
  );

  assign start_rise = start & ~start_q;
  assign key_c      = KW'(lfsr_q);

  // next-state, datapath updates and PQ requests
  always_comb begin
    state_d   = state_q;
    n_add_d   = n_add_q;
    n_rem_d   = n_rem_q;
    sum_in_d  = sum_in_q;
    sum_out_d = sum_out_q;
    prev_d    = prev_q;
    last_d    = last_q;
    err_d     = err_q;
    pass_d    = pass_q;
    tmo_d     = tmo_q;
    out_d     = out_q;
    enq_c     = 1'b0;
    deq_c     = 1'b0;
    wait_c    = 1'b0;
    lfsr_ld   = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      IDLE, DISPLAY: if (start_rise) state_d = START;
      START: begin
        n_add_d   = '0;
        n_rem_d   = '0;
        sum_in_d  = '0;
        sum_out_d = '0;
        err_d     = ERR_NONE;
        pass_d    = 1'b0;
        prev_d    = '1;
        tmo_d     = '0;
        out_d     = 1'b0;
        lfsr_ld   = 1'b1;
        state_d   = ADD;
      end
      ADD: begin
        if (pq.full || n_add_q == NW'(DEPTH)) begin
          state_d = FULL;
        end else if (pq.ready) begin
          enq_c    = 1'b1;
          sum_in_d = sum_in_q + SW'(key_c);
          n_add_d  = n_add_q + 1'b1;
          lfsr_adv = 1'b1;
          tmo_d    = '0;
        end else begin
          wait_c = 1'b1;
        end
      end
      FULL: begin
        tmo_d   = '0;
        state_d = REMOVE;
      end
      REMOVE: begin
        if (out_q) begin
          if (pq.dout_valid) begin
            last_d    = pq.dout;
            if (pq.dout > prev_q && err_q == ERR_NONE) err_d = ERR_ORDER;
            prev_d    = pq.dout;
            sum_out_d = sum_out_q + SW'(pq.dout);
            n_rem_d   = n_rem_q + 1'b1;
            out_d     = 1'b0;
            tmo_d     = '0;
          end else begin
            wait_c = 1'b1;
          end
        end else if (pq.empty) begin
          state_d = EMPTY;
        end else if (pq.ready) begin
          deq_c = 1'b1;
          out_d = 1'b1;
          tmo_d = '0;
        end else begin
          wait_c = 1'b1;
        end
      end
      EMPTY: begin
        if (err_q == ERR_NONE) begin
          if (n_rem_q != n_add_q)        err_d = ERR_COUNT;
          else if (sum_out_q != sum_in_q) err_d = ERR_SUM;
        end
        pass_d  = (err_d == ERR_NONE);
        state_d = DISPLAY;
      end
      default: state_d = IDLE;
    endcase
    // stalled cycles in ADD/REMOVE count toward the abort limit
    if (wait_c) begin
      if (tmo_q == TW'(TIMEOUT-1)) begin
        err_d   = ERR_TMO;
        pass_d  = 1'b0;
        state_d = DISPLAY;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    // a reset cycle must never emit a request, even mid-run
    if (!rst) begin
      enq_c = 1'b0;
      deq_c = 1'b0;
    end
  end

  // registers; flags are decoded from the next state so they move with it
  always_ff @(posedge clk) begin
    start_q <= start;
    if (!rst) begin
      state_q   <= IDLE;
      flags_q   <= 7'd1 << IDLE;
      n_add_q   <= '0;
      n_rem_q   <= '0;
      sum_in_q  <= '0;
      sum_out_q <= '0;
      prev_q    <= '0;
      last_q    <= '0;
      err_q     <= ERR_NONE;
      pass_q    <= 1'b0;
      tmo_q     <= '0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= 7'd1 << state_d;
      n_add_q   <= n_add_d;
      n_rem_q   <= n_rem_d;
      sum_in_q  <= sum_in_d;
      sum_out_q <= sum_out_d;
      prev_q    <= prev_d;
      last_q    <= last_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      tmo_q     <= tmo_d;
      out_q     <= out_d;
    end
  end

  assign pq.enq      = enq_c;
  assign pq.deq      = deq_c;
  assign pq.din      = enq_c ? key_c : '0;

  assign sig_idle    = flags_q[IDLE];
  assign sig_start   = flags_q[START];
  assign sig_add     = flags_q[ADD];
  assign sig_full    = flags_q[FULL];
  assign sig_remove  = flags_q[REMOVE];
  assign sig_empty   = flags_q[EMPTY];
  assign sig_display = flags_q[DISPLAY];
  assign n_added     = n_add_q;
  assign last_key    = last_q;
  assign pass        = pass_q;
  assign err_code    = err_q;
endmodule

// File: tb/tb_pq_auto_ctrl.sv
// Directed bench: behavioural capacity-4 max-PQ with swap/drop fault modes.
module tb_pq_auto_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ready_en = 1'b1;
  logic model_clr = 1'b0;
  int   mode = 0;  // 0 normal, 1 swap first two outputs, 2 drop one key

  logic sig_idle, sig_start, sig_add, sig_remove, sig_display, sig_full, sig_empty;
  logic [4:0]  n_added;
  logic [15:0] last_key;
  logic        pass;
  logic [2:0]  err_code;

  int n_tot = 0;
  int n_bad = 0;
  int both_cnt = 0;
  int illegal_cnt = 0;

  pq_auto_ctrl_if #(.KW(16)) pq_if ();

  pq_auto_ctrl #(.KW(16), .DEPTH(16), .SEED(16'hACE1), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .pq(pq_if),
    .sig_idle(sig_idle), .sig_start(sig_start), .sig_add(sig_add),
    .sig_remove(sig_remove), .sig_display(sig_display), .sig_full(sig_full),
    .sig_empty(sig_empty), .n_added(n_added), .last_key(last_key),
    .pass(pass), .err_code(err_code)
  );

  always #5 clk = ~clk;

  wire [6:0] flags = {sig_idle, sig_start, sig_add, sig_remove, sig_display, sig_full, sig_empty};
  localparam logic [6:0] F_IDLE = 7'b1000000;
  localparam logic [6:0] F_DISP = 7'b0000100;

  // behavioural PQ
  logic [15:0] mq[$];
  logic [15:0] enq_log[$];
  logic [15:0] deq_log[$];
  int ndeq = 0;

  assign pq_if.ready = ready_en;
  initial begin
    pq_if.full = 1'b0;
    pq_if.empty = 1'b1;
    pq_if.dout = '0;
    pq_if.dout_valid = 1'b0;
  end

  function automatic logic [15:0] popmax();
    int bi = 0;
    logic [15:0] k;
    for (int i = 1; i < mq.size(); i++) if (mq[i] > mq[bi]) bi = i;
    k = mq[bi];
    mq.delete(bi);
    return k;
  endfunction

  always @(posedge clk) begin
    logic [15:0] k, k2;
    pq_if.dout_valid <= 1'b0;
    if (model_clr) begin
      mq.delete(); enq_log.delete(); deq_log.delete(); ndeq = 0;
    end else begin
      if (pq_if.enq) begin
        enq_log.push_back(pq_if.din);
        if (mq.size() < 4) mq.push_back(pq_if.din);
      end
      if (pq_if.deq && mq.size() > 0) begin
        k = popmax();
        if (mode == 1 && ndeq == 0 && mq.size() > 0) begin
          k2 = popmax(); mq.push_back(k); k = k2;
        end else if (mode == 2 && ndeq == 0 && mq.size() > 0) begin
          k2 = popmax();
        end
        pq_if.dout <= k;
        pq_if.dout_valid <= 1'b1;
        deq_log.push_back(k);
        ndeq++;
      end
    end
    pq_if.full  <= (mq.size() >= 4);
    pq_if.empty <= (mq.size() == 0);
  end

  // request-legality monitor
  always @(negedge clk) begin
    if (pq_if.enq && pq_if.deq) both_cnt++;
    if ((pq_if.enq || pq_if.deq) && !(sig_add || sig_remove)) illegal_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_model();
    model_clr = 1'b1; tick(); model_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b0; tick(); start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_disp(input string tag, input int bound);
    int n = 0;
    while (!sig_display && n < bound) begin tick(); n++; end
    chk(tag, {31'd0, sig_display}, 32'd1);
  endtask

  initial begin
    int n, add_cyc;
    // reset state
    rst = 1'b0; model_clr = 1'b1;
    tick(); tick();
    chk("rst_flags", {25'd0, flags}, {25'd0, F_IDLE});
    chk("rst_nadd", {27'd0, n_added}, 32'd0);
    chk("rst_last", {16'd0, last_key}, 32'd0);
    chk("rst_pass_err", {28'd0, pass, err_code}, 32'd0);
    chk("rst_req", {30'd0, pq_if.enq, pq_if.deq}, 32'd0);
    rst = 1'b1; model_clr = 1'b0;
    tick();

    // normal run
    pulse_start();
    chk("run_start_flag", {31'd0, sig_start}, 32'd1);
    wait_disp("run_disp", 300);
    chk("enq_n", enq_log.size(), 32'd4);
    chk("enq0", {16'd0, enq_log[0]}, 32'hACE1);
    chk("enq1", {16'd0, enq_log[1]}, 32'hE270);
    chk("enq2", {16'd0, enq_log[2]}, 32'h7138);
    chk("enq3", {16'd0, enq_log[3]}, 32'h389C);
    chk("deq0", {16'd0, deq_log[0]}, 32'hE270);
    chk("deq1", {16'd0, deq_log[1]}, 32'hACE1);
    chk("deq2", {16'd0, deq_log[2]}, 32'h7138);
    chk("deq3", {16'd0, deq_log[3]}, 32'h389C);
    chk("sum_in", {12'd0, dut.sum_in_q}, 32'h23925);
    chk("run_pass", {31'd0, pass}, 32'd1);
    chk("run_err", {29'd0, err_code}, 32'd0);
    chk("run_nadd", {27'd0, n_added}, 32'd4);
    chk("run_last", {16'd0, last_key}, 32'h389C);
    chk("run_flags", {25'd0, flags}, {25'd0, F_DISP});

    // start held high: one run only, then a fresh edge reruns identically
    clr_model();
    start = 1'b1; tick();
    wait_disp("hold_disp", 300);
    repeat (20) tick();
    chk("hold_stay", {25'd0, flags}, {25'd0, F_DISP});
    chk("hold_enq_n", enq_log.size(), 32'd4);
    clr_model();
    start = 1'b0; tick(); start = 1'b1; tick();
    chk("rerun_start", {31'd0, sig_start}, 32'd1);
    wait_disp("rerun_disp", 300);
    chk("rerun_enq0", {16'd0, enq_log[0]}, 32'hACE1);
    chk("rerun_enq3", {16'd0, enq_log[3]}, 32'h389C);
    chk("rerun_pass", {31'd0, pass}, 32'd1);
    start = 1'b0;

    // swapped output order
    mode = 1; clr_model();
    pulse_start();
    wait_disp("swap_disp", 300);
    chk("swap_err", {29'd0, err_code}, 32'd1);
    chk("swap_pass", {31'd0, pass}, 32'd0);
    chk("swap_deq_n", deq_log.size(), 32'd4);

    // dropped key
    mode = 2; clr_model();
    pulse_start();
    wait_disp("drop_disp", 300);
    chk("drop_err", {29'd0, err_code}, 32'd2);
    chk("drop_pass", {31'd0, pass}, 32'd0);
    chk("drop_nadd", {27'd0, n_added}, 32'd4);

    // timeout while stuck in ADD
    mode = 0; clr_model(); ready_en = 1'b0;
    pulse_start();
    n = 0; add_cyc = 0;
    while (!sig_display && n < 2000) begin
      tick(); n++;
      if (sig_add) add_cyc++;
    end
    chk("tmo_disp", {31'd0, sig_display}, 32'd1);
    chk("tmo_cycles", add_cyc, 32'd1024);
    chk("tmo_err", {29'd0, err_code}, 32'd4);
    chk("tmo_pass", {31'd0, pass}, 32'd0);
    chk("tmo_enq_n", enq_log.size(), 32'd0);
    ready_en = 1'b1;

    // reset during REMOVE, then clean rerun
    clr_model();
    pulse_start();
    n = 0;
    while (!sig_remove && n < 200) begin tick(); n++; end
    chk("mid_in_remove", {31'd0, sig_remove}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_flags", {25'd0, flags}, {25'd0, F_IDLE});
    chk("mid_req", {30'd0, pq_if.enq, pq_if.deq}, 32'd0);
    chk("mid_outs", {n_added, last_key, pass, err_code}, 32'd0);
    rst = 1'b1;
    n = deq_log.size();
    repeat (5) tick();
    chk("mid_no_deq", deq_log.size(), n);
    chk("mid_idle", {25'd0, flags}, {25'd0, F_IDLE});
    clr_model();
    pulse_start();
    wait_disp("mid_rerun_disp", 300);
    chk("mid_rerun_pass", {31'd0, pass}, 32'd1);
    chk("mid_rerun_deq3", {16'd0, deq_log[3]}, 32'h389C);

    chk("enq_deq_both", both_cnt, 32'd0);
    chk("req_outside", illegal_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
